fburg_bus_master: RTL and testbench
===================================

FBURG_BUS_MASTER -- requirements
Module: fburg_bus_master

Interface
REQ-001 SHALL have parameter SETUP, default 1: cycles Addr/Cs are valid before the strobe asserts (legal range 1..15).
REQ-002 SHALL have parameter STROBE, default 2: minimum cycles Rd/Wr are held low (legal range 1..15).
REQ-003 SHALL have parameter HOLD, default 1: cycles Addr/Cs/write data are held after the strobe deasserts (legal range 1..15).
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum consecutive Wait-high cycles tolerated in STROBE (legal range 1..65535).
REQ-005 SHALL have one clock and a synchronous, active-high reset: Clk input 1, the single rising-edge clock; Rst input 1, synchronous active-high reset.
REQ-006 SHALL have the following host-side ports.
- Req input 1: single-cycle request strobe.
- ReqWr input 1: 1 = write, 0 = read.
- ReqAddr input 12: target address.
- ReqWdata input 16: write data.
- ReqCs input 1: selects Cs[0] (0) or Cs[1] (1).
- Busy output 1: transaction in progress.
- Ack output 1: one-cycle completion pulse.
- Err output 1: timeout flag, valid with Ack.
- Rdata output 16: read data, valid with Ack, held until the next read Ack.
REQ-007 SHALL have the following bus-side ports.
- Addr output 12: bus address.
- DataOut output 16: drive data.
- DataOe output 1: pad enable for DataOut.
- DataIn input 16: bus data in.
- Rd output 1: active-low read strobe.
- Wr output 1: active-low write strobe.
- Cs output 2: active-low chip selects.
- Wait input 1: high = responder stretching the strobe.

Function
REQ-010 SHALL implement the FSM states IDLE, SETUP, STROBE and HOLD, with all bus and host outputs registered.
REQ-011 SHALL, in IDLE with Req=1, latch ReqWr/ReqAddr/ReqWdata/ReqCs, set Busy=1 and enter SETUP on the next cycle.
REQ-012 SHALL ignore Req while Busy=1, with no queuing.
REQ-013 SHALL, in SETUP, drive Addr from the latched address and pull the selected Cs bit low, keeping Rd=Wr=1.
REQ-014 SHALL stay in SETUP for exactly SETUP cycles.
REQ-015 SHALL drive DataOe=1 and DataOut=ReqWdata from SETUP through the end of HOLD on writes, and DataOe=0 on reads.
REQ-016 SHALL, in STROBE, drive Rd=0 (read) or Wr=0 (write) for at least STROBE cycles.
REQ-017 SHALL extend STROBE while Wait=1 is sampled on the final counted cycle or on any later cycle.
REQ-018 SHALL leave STROBE on the first such cycle that samples Wait=0.
REQ-019 SHALL, on reads, capture DataIn into Rdata at the clock edge that leaves STROBE.
REQ-020 SHALL count consecutive Wait=1 cycles in STROBE; when the count reaches TIMEOUT, it SHALL leave STROBE, set the Err result, leave Rdata unchanged and proceed to HOLD.
REQ-021 SHALL, in HOLD, drive Rd=Wr=1 with Addr, Cs and DataOe unchanged for exactly HOLD cycles, then return to IDLE.
REQ-022 SHALL, on the first IDLE cycle after HOLD, drive Ack=1 for one cycle, with Err valid and Busy=0.
REQ-023 SHALL accept a Req presented in the Ack cycle, giving back-to-back transactions with no dead cycle.
REQ-024 SHALL, in IDLE, drive Cs=2'b11, Rd=Wr=1 and DataOe=0; Addr and DataOut hold their last values.
REQ-025 SHALL never assert Rd and Wr low simultaneously, and SHALL never assert both Cs bits low.
REQ-026 SHALL have a Req-to-Ack latency of SETUP+STROBE+HOLD+1 cycles plus any Wait extension.

Reset
REQ-030 SHALL, while Rst=1 at a Clk edge, enter IDLE and reset outputs as follows.
- Cs=2'b11, Rd=1, Wr=1, DataOe=0.
- Busy=0, Ack=0, Err=0.
- Rdata=0, Addr=0, DataOut=0.
- Wait counter cleared.
REQ-031 SHALL abort any transaction in progress when Rst asserts, with no Ack issued, and the bus SHALL be released on the cycle after Rst is sampled.

Verification
REQ-040 SHALL cover a default-parameter write: Req, ReqWr=1, ReqAddr=12'h002, ReqWdata=16'h1234, ReqCs=0 -> Cs=2'b10 for 4 cycles, Wr=0 for cycles 2-3, DataOe=1 for 4 cycles, Ack at cycle 5, Err=0.
REQ-041 SHALL cover a read: ReqAddr=12'h000 with the responder model returning 16'hBEEF -> Rd=0 for 2 cycles, Ack at cycle 5, Rdata=16'hBEEF.
REQ-042 SHALL cover Wait stretching: Wait=1 for 3 cycles starting at the second STROBE cycle -> Rd low for 5 cycles, Ack at cycle 8, Err=0.
REQ-043 SHALL cover a timeout: TIMEOUT=4 and Wait stuck at 1 -> strobe released after 4 Wait cycles, Ack with Err=1, Rdata unchanged.
REQ-044 SHALL cover back-to-back requests: a second Req on the Ack cycle is accepted and Busy remains 0 for only that one cycle; a Req while Busy=1 is ignored.
REQ-045 SHALL cover mid-STROBE reset: Rst=1 for 1 cycle -> next cycle Cs=2'b11, Rd=Wr=1, Busy=0, no Ack.

Source files
------------

// File: rtl/fburg_bus_master.sv
// fburg_bus_master: single-transaction parallel bus master with a strobe-based
// handshake. The master issues one read or write at a time. Each transfer runs
// in three timed phases:
//   - setup:  address and chip select are valid.
//   - strobe: Rd or Wr is low. The responder can stretch this phase with Wait.
//   - hold:   address and chip select stay valid after the strobe rises.
// If Wait stays high too long, the master abandons the strobe and reports Err.
//
// Ports
//   Clk, Rst               rising-edge clock, synchronous active-high reset
//   Req/ReqWr/ReqAddr/
//   ReqWdata/ReqCs         host request (sampled only while idle)
//   Busy/Ack/Err/Rdata     host status; Ack is a one-cycle completion pulse
//   Addr/DataOut/DataOe    bus address and write-data drive
//   DataIn                 bus read data
//   Rd/Wr/Cs               active-low strobes and chip selects
//   Wait                   responder stretch request
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | bus released, waiting for Req; Ack pulses on first cycle
// ST_SETUP  | Addr/Cs valid, strobes high, SETUP cycles
// ST_STROBE | Rd or Wr low, >= STROBE cycles, stretched by Wait
// ST_HOLD   | strobes high, Addr/Cs/DataOe held, HOLD cycles

module fburg_bus_master #(
    parameter int unsigned SETUP   = 1,
    parameter int unsigned STROBE  = 2,
    parameter int unsigned HOLD    = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic        ReqWr,
    input  logic [11:0] ReqAddr,
    input  logic [15:0] ReqWdata,
    input  logic        ReqCs,
    output logic        Busy,
    output logic        Ack,
    output logic        Err,
    output logic [15:0] Rdata,
    output logic [11:0] Addr,
    output logic [15:0] DataOut,
    output logic        DataOe,
    input  logic [15:0] DataIn,
    output logic        Rd,
    output logic        Wr,
    output logic [1:0]  Cs,
    input  logic        Wait
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

    localparam logic [3:0]  SETUP_M1   = 4'(SETUP - 1);
    localparam logic [3:0]  STROBE_M1  = 4'(STROBE - 1);
    localparam logic [3:0]  HOLD_M1    = 4'(HOLD - 1);
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;      // phase down-counter, terminal count at zero
    logic [15:0] wcnt_q;     // consecutive Wait=1 cycles seen in strobe
    logic        is_wr_q;
    logic        err_pend_q;
    logic        busy_q, ack_q, err_q, oe_q, rd_q, wr_q;
    logic [1:0]  cs_q;
    logic [11:0] addr_q;
    logic [15:0] dout_q, rdata_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            is_wr_q    <= 1'b0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            oe_q       <= 1'b0;
            rd_q       <= 1'b1;
            wr_q       <= 1'b1;
            cs_q       <= 2'b11;
            addr_q     <= '0;
            dout_q     <= '0;
            rdata_q    <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Req) begin
                        is_wr_q    <= ReqWr;
                        addr_q     <= ReqAddr;
                        if (ReqWr) dout_q <= ReqWdata;
                        oe_q       <= ReqWr;
                        cs_q       <= ReqCs ? 2'b01 : 2'b10;
                        busy_q     <= 1'b1;
                        err_pend_q <= 1'b0;
                        wcnt_q     <= '0;
                        cnt_q      <= SETUP_M1;
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == 4'd0) begin
                        rd_q    <= is_wr_q;
                        wr_q    <= ~is_wr_q;
                        cnt_q   <= STROBE_M1;
                        state_q <= ST_STROBE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_STROBE: begin
                    // Timeout takes priority: the current cycle would be the
                    // TIMEOUT-th consecutive Wait=1 cycle.
                    if (Wait && (wcnt_q == TIMEOUT_M1)) begin
                        err_pend_q <= 1'b1;
                        rd_q       <= 1'b1;
                        wr_q       <= 1'b1;
                        wcnt_q     <= '0;
                        cnt_q      <= HOLD_M1;
                        state_q    <= ST_HOLD;
                    end else if ((cnt_q == 4'd0) && !Wait) begin
                        if (!is_wr_q) rdata_q <= DataIn;
                        rd_q    <= 1'b1;
                        wr_q    <= 1'b1;
                        wcnt_q  <= '0;
                        cnt_q   <= HOLD_M1;
                        state_q <= ST_HOLD;
                    end else begin
                        if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                        wcnt_q <= Wait ? (wcnt_q + 16'd1) : 16'd0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 4'd0) begin
                        cs_q    <= 2'b11;
                        oe_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        ack_q   <= 1'b1;
                        err_q   <= err_pend_q;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Busy    = busy_q;
    assign Ack     = ack_q;
    assign Err     = err_q;
    assign Rdata   = rdata_q;
    assign Addr    = addr_q;
    assign DataOut = dout_q;
    assign DataOe  = oe_q;
    assign Rd      = rd_q;
    assign Wr      = wr_q;
    assign Cs      = cs_q;

endmodule

// File: tb/tb_fburg_bus_master.sv
module tb_fburg_bus_master;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, req_t, req_wr, req_cs, wait_i;
    logic [11:0] req_addr;
    logic [15:0] req_wdata;

    logic        busy, ack, err, doe, rd, wr;
    logic [15:0] rdata, dout, din;
    logic [11:0] addr;
    logic [1:0]  cs;

    logic        t_busy, t_ack, t_err, t_doe, t_rd, t_wr;
    logic [15:0] t_rdata, t_dout, t_din;
    logic [11:0] t_addr;
    logic [1:0]  t_cs;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    // Responder: address 0 returns BEEF, others return A000 | address.
    function automatic logic [15:0] resp(input logic [11:0] a);
        return (a == 12'h000) ? 16'hBEEF : (16'hA000 | {4'h0, a});
    endfunction

    assign din   = resp(addr);
    assign t_din = resp(t_addr);

    fburg_bus_master dut (
        .Clk(clk), .Rst(rst), .Req(req), .ReqWr(req_wr), .ReqAddr(req_addr),
        .ReqWdata(req_wdata), .ReqCs(req_cs), .Busy(busy), .Ack(ack), .Err(err),
        .Rdata(rdata), .Addr(addr), .DataOut(dout), .DataOe(doe), .DataIn(din),
        .Rd(rd), .Wr(wr), .Cs(cs), .Wait(wait_i)
    );

    fburg_bus_master #(.TIMEOUT(4)) dut_to (
        .Clk(clk), .Rst(rst), .Req(req_t), .ReqWr(req_wr), .ReqAddr(req_addr),
        .ReqWdata(req_wdata), .ReqCs(req_cs), .Busy(t_busy), .Ack(t_ack), .Err(t_err),
        .Rdata(t_rdata), .Addr(t_addr), .DataOut(t_dout), .DataOe(t_doe), .DataIn(t_din),
        .Rd(t_rd), .Wr(t_wr), .Cs(t_cs), .Wait(wait_i)
    );

    always @(negedge clk) begin
        if ((rd === 1'b0 && wr === 1'b0) || cs === 2'b00 ||
            (t_rd === 1'b0 && t_wr === 1'b0) || t_cs === 2'b00)
            viol++;
    end

    function automatic logic [6:0] st();
        return {cs, rd, wr, doe, busy, ack};
    endfunction

    function automatic logic [6:0] tst();
        return {t_cs, t_rd, t_wr, t_doe, t_busy, t_ack};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; req_t = 1'b0; req_wr = 1'b0; req_cs = 1'b0;
        wait_i = 1'b0; req_addr = '0; req_wdata = '0;
        step(); step();
        rst = 1'b0;
        step();
        checks++;
        if (st() !== 7'b11_1_1_0_0_0) begin
            errors++; $display("FAIL reset_status got %b want %b", st(), 7'b11_1_1_0_0_0);
        end
        checks++;
        if ({err, rdata, addr, dout} !== 45'd0) begin
            errors++; $display("FAIL reset_data err=%b rdata=%h addr=%h dout=%h want all 0", err, rdata, addr, dout);
        end
        checks++;
        if (tst() !== 7'b11_1_1_0_0_0 || t_dout !== 16'h0 || t_rdata !== 16'h0) begin
            errors++; $display("FAIL reset_to status=%b dout=%h rdata=%h want 1111000/0/0", tst(), t_dout, t_rdata);
        end
    endtask

    task automatic test_write();
        logic [6:0] exp [6] = '{7'b10_1_1_1_1_0, 7'b10_1_0_1_1_0, 7'b10_1_0_1_1_0,
                                7'b10_1_1_1_1_0, 7'b11_1_1_0_0_1, 7'b11_1_1_0_0_0};
        req = 1'b1; req_wr = 1'b1; req_addr = 12'h002; req_wdata = 16'h1234; req_cs = 1'b0;
        step();
        req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (st() !== exp[c-1]) begin
                errors++; $display("FAIL write_c%0d got %b want %b", c, st(), exp[c-1]);
            end
            if (c == 2) begin
                checks++;
                if (addr !== 12'h002 || dout !== 16'h1234) begin
                    errors++; $display("FAIL write_bus addr=%h dout=%h want 002/1234", addr, dout);
                end
            end
            if (c == 5) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++; $display("FAIL write_err got %b want 0", err);
                end
            end
            step();
        end
    endtask

    task automatic test_read();
        logic [6:0] exp [5] = '{7'b01_1_1_0_1_0, 7'b01_0_1_0_1_0, 7'b01_0_1_0_1_0,
                                7'b01_1_1_0_1_0, 7'b11_1_1_0_0_1};
        req = 1'b1; req_wr = 1'b0; req_addr = 12'h000; req_wdata = 16'hFFFF; req_cs = 1'b1;
        step();
        req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (st() !== exp[c-1]) begin
                errors++; $display("FAIL read_c%0d got %b want %b", c, st(), exp[c-1]);
            end
            if (c == 2) begin
                checks++;
                if (dout !== 16'h1234) begin
                    errors++; $display("FAIL read_dout_held got %h want 1234", dout);
                end
            end
            if (c == 5) begin
                checks++;
                if (rdata !== 16'hBEEF || err !== 1'b0) begin
                    errors++; $display("FAIL read_data rdata=%h err=%b want BEEF/0", rdata, err);
                end
            end
            step();
        end
    endtask

    task automatic test_wait_stretch();
        logic [6:0] exp [9] = '{7'b10_1_1_0_1_0, 7'b10_0_1_0_1_0, 7'b10_0_1_0_1_0,
                                7'b10_0_1_0_1_0, 7'b10_0_1_0_1_0, 7'b10_0_1_0_1_0,
                                7'b10_1_1_0_1_0, 7'b11_1_1_0_0_1, 7'b11_1_1_0_0_0};
        req = 1'b1; req_wr = 1'b0; req_addr = 12'h001; req_cs = 1'b0;
        step();
        req = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 3) wait_i = 1'b1;
            if (c == 6) wait_i = 1'b0;
            checks++;
            if (st() !== exp[c-1]) begin
                errors++; $display("FAIL wait_c%0d got %b want %b", c, st(), exp[c-1]);
            end
            if (c == 8) begin
                checks++;
                if (rdata !== 16'hA001 || err !== 1'b0) begin
                    errors++; $display("FAIL wait_data rdata=%h err=%b want A001/0", rdata, err);
                end
            end
            step();
        end
    endtask

    task automatic test_timeout();
        logic [6:0] exp [8] = '{7'b10_1_1_0_1_0, 7'b10_0_1_0_1_0, 7'b10_0_1_0_1_0,
                                7'b10_0_1_0_1_0, 7'b10_0_1_0_1_0, 7'b10_1_1_0_1_0,
                                7'b11_1_1_0_0_1, 7'b11_1_1_0_0_0};
        req_t = 1'b1; req_wr = 1'b0; req_addr = 12'h000; req_cs = 1'b0;
        step();
        req_t = 1'b0;
        for (int c = 1; c <= 5; c++) step();
        checks++;
        if (t_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL timeout_preread rdata=%h want BEEF", t_rdata);
        end
        req_t = 1'b1; req_addr = 12'h005; wait_i = 1'b1;
        step();
        req_t = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (tst() !== exp[c-1]) begin
                errors++; $display("FAIL timeout_c%0d got %b want %b", c, tst(), exp[c-1]);
            end
            if (c == 7) begin
                checks++;
                if (t_err !== 1'b1 || t_rdata !== 16'hBEEF) begin
                    errors++; $display("FAIL timeout_result err=%b rdata=%h want 1/BEEF", t_err, t_rdata);
                end
                wait_i = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp [11] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10,
                                 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
        req = 1'b1; req_wr = 1'b1; req_addr = 12'h003; req_wdata = 16'h5555; req_cs = 1'b0;
        step();
        req = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if ({busy, ack} !== exp[c-1]) begin
                errors++; $display("FAIL b2b_c%0d busy/ack got %b want %b", c, {busy, ack}, exp[c-1]);
            end
            if (c == 3) begin
                checks++;
                if (addr !== 12'h003) begin
                    errors++; $display("FAIL b2b_ignored addr=%h want 003", addr);
                end
            end
            if (c == 6) begin
                checks++;
                if (cs !== 2'b01 || addr !== 12'h000) begin
                    errors++; $display("FAIL b2b_second cs=%b addr=%h want 01/000", cs, addr);
                end
            end
            if (c == 10) begin
                checks++;
                if (rdata !== 16'hBEEF) begin
                    errors++; $display("FAIL b2b_rdata got %h want BEEF", rdata);
                end
            end
            req = 1'b0;
            if (c == 2) begin
                req = 1'b1; req_wr = 1'b0; req_addr = 12'h0F0; req_cs = 1'b1;
            end
            if (c == 5) begin
                req = 1'b1; req_wr = 1'b0; req_addr = 12'h000; req_cs = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        int acks = 0;
        req = 1'b1; req_wr = 1'b1; req_addr = 12'h007; req_wdata = 16'hAAAA; req_cs = 1'b1;
        step();
        req = 1'b0;
        step();
        checks++;
        if (st() !== 7'b01_1_0_1_1_0) begin
            errors++; $display("FAIL midrst_strobe got %b want %b", st(), 7'b01_1_0_1_1_0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (st() !== 7'b11_1_1_0_0_0) begin
            errors++; $display("FAIL midrst_release got %b want %b", st(), 7'b11_1_1_0_0_0);
        end
        for (int c = 0; c < 6; c++) begin
            if (ack === 1'b1) acks++;
            step();
        end
        checks++;
        if (acks !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_noack acks=%0d busy=%b want 0/0", acks, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wait_stretch();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL exclusivity violations=%0d want 0", viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
